// File: rtl/mem_arbiter_pkg.sv
// mem_arb_pkg: shared types and default widths for the memory arbiter slice.
//   state_t  : arbiter FSM states
//   grant_t  : one-hot owner encoding driven on the grant port
//   *_DEF    : default address/data widths and memory latency
package mem_arb_pkg;

  localparam int ADDR_W_DEF  = 16;
  localparam int DATA_W_DEF  = 16;
  localparam int MEM_LAT_DEF = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    GNT_NONE = 2'b00,
    GNT_IF   = 2'b01,
    GNT_DM   = 2'b10
  } grant_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester and shared-memory signals of the arbiter.
//   slave  modport : arbiter side (takes requests and mem_rdata, drives acks,
//                    rdata, memory strobes, grant, busy)
//   master modport : environment side (instruction fetch, data path, memory)
interface mem_arbiter_if import mem_arb_pkg::*; #(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ack;
  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_ack;
  logic [DATA_W-1:0] rdata;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic [1:0]        grant;
  logic              busy;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    output if_ack, dm_ack, rdata, mem_en, mem_we, mem_addr, mem_wdata, grant, busy
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    input  if_ack, dm_ack, rdata, mem_en, mem_we, mem_addr, mem_wdata, grant, busy
  );

endinterface

// File: rtl/mem_arbiter_arb_select.sv
// arb_select: combinational winner selection between fetch and data requests.
//   if_req, dm_req : pending requests
//   last_dm        : 1 = data port was granted last, 0 = fetch was granted last
//   winner         : GNT_IF / GNT_DM / GNT_NONE
// A tie goes to whichever port was not granted last; with last_dm tied low
// this reduces to fixed data-over-fetch priority.
module arb_select import mem_arb_pkg::*; (
  input  logic   if_req,
  input  logic   dm_req,
  input  logic   last_dm,
  output grant_t winner
);

  always_comb begin
    winner = GNT_NONE;
    if (if_req && dm_req) begin
      winner = last_dm ? GNT_IF : GNT_DM;
    end else if (dm_req) begin
      winner = GNT_DM;
    end else if (if_req) begin
      winner = GNT_IF;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between instruction fetch and data access.
//   clk, reset : single clock, asynchronous active-high reset
//   bus        : mem_arbiter_if.slave (requests, acks, rdata, memory strobes,
//                grant, busy); all outputs registered
// Optional build macro ARB_RR_EN: ties alternate between the two requesters.
// Without it, the data port always wins a tie.
//
//   state | meaning
//   IDLE  | no transaction; sample requests and latch the winner
//   ISSUE | one-cycle mem_en strobe, latency counter loaded
//   WAIT  | count down memory latency, capture read data at zero
//   RESP  | ack pulse to the granted requester
// ack rises MEM_LAT+2 edges after the sampling edge.
module mem_arbiter import mem_arb_pkg::*; #(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int MEM_LAT = MEM_LAT_DEF
) (
  input logic          clk,
  input logic          reset,
  mem_arbiter_if.slave bus
);

  localparam logic [2:0] LAT_CNT = 3'(MEM_LAT);

  state_t            state;
  grant_t            winner;
  grant_t            grant_q;
  logic [2:0]        cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              we_q;
  logic              busy_q;
  logic              mem_en_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              if_ack_q;
  logic              dm_ack_q;
  logic              last_dm;

`ifdef ARB_RR_EN
  // Reset leaves the pointer at fetch-last so the first tie goes to data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_dm <= 1'b0;
    end else if (state == IDLE && winner != GNT_NONE) begin
      last_dm <= (winner == GNT_DM);
    end
  end
`else
  assign last_dm = 1'b0;
`endif

  arb_select u_sel (
    .if_req  (bus.if_req),
    .dm_req  (bus.dm_req),
    .last_dm (last_dm),
    .winner  (winner)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      grant_q     <= GNT_NONE;
      cnt         <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      busy_q      <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
      if_ack_q    <= 1'b0;
      dm_ack_q    <= 1'b0;
    end else begin
      mem_en_q <= 1'b0;
      mem_we_q <= 1'b0;
      if_ack_q <= 1'b0;
      dm_ack_q <= 1'b0;
      case (state)
        IDLE: begin
          if (winner != GNT_NONE) begin
            grant_q <= winner;
            busy_q  <= 1'b1;
            state   <= ISSUE;
            if (winner == GNT_DM) begin
              addr_q  <= bus.dm_addr;
              wdata_q <= bus.dm_wdata;
              we_q    <= bus.dm_we;
            end else begin
              // fetch is read-only, so we_q can never raise mem_we for it
              addr_q  <= bus.if_addr;
              wdata_q <= '0;
              we_q    <= 1'b0;
            end
          end
        end
        ISSUE: begin
          mem_en_q    <= 1'b1;
          mem_we_q    <= we_q;
          mem_addr_q  <= addr_q;
          mem_wdata_q <= wdata_q;
          cnt         <= LAT_CNT;
          state       <= WAIT;
        end
        WAIT: begin
          // counter hits zero on the last wait edge; mem_rdata is valid on the next
          if (cnt == 3'd0) begin
            rdata_q  <= we_q ? '0 : bus.mem_rdata;
            if_ack_q <= (grant_q == GNT_IF);
            dm_ack_q <= (grant_q == GNT_DM);
            state    <= RESP;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        RESP: begin
          grant_q <= GNT_NONE;
          busy_q  <= 1'b0;
          rdata_q <= '0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.grant     = grant_q;
  assign bus.busy      = busy_q;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.rdata     = rdata_q;
  assign bus.if_ack    = if_ack_q;
  assign bus.dm_ack    = dm_ack_q;

endmodule
